bp_fe_tournament_bht: RTL and testbench

Parametrised tournament branch direction predictor for the front end. It combines three predictors:
- a per-PC local-history predictor,
- a gshare global predictor,
- a per-PC chooser that selects between the two.

It replaces the single-table BHT in the IF0/IF1 path of the PC generator: read in IF0, prediction returned in IF1. Updates arrive from attaboy/redirect traffic through a valid/yumi handshake. The update is read-modify-write using returned metadata, so it needs no table read.

---
 rtl/bp_fe_tournament_bht.sv | 229 ++++++++++++++++++++++
 tb/tb_bp_fe_tournament_bht.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_tournament_bht.sv
// ---------------------------------------------------------------------------
// bp_fe_tournament_bht
//
// Tournament branch direction predictor for the fetch front end. It has three
// parts:
//   - a per-PC local-history predictor (lhist flop table feeding a local PHT),
//   - a gshare global predictor (global history XOR PC indexing a global PHT),
//   - a per-PC chooser that picks which of the two predictions to use.
// A read is issued in IF0 and its prediction is returned in IF1. Updates come
// back with the metadata captured at prediction time, so an update never has
// to read the counter arrays. It only needs the current lhist entry, which
// lives in flops.
//
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset
//   init_done_o  tables cleared, traffic accepted
//   r_v_i        read request (IF0)
//   r_addr_i     fetch PC
//   r_ghist_i    speculative global history
//   pred_v_o     pred_o / meta_o valid (IF1)
//   pred_o       predicted taken
//   meta_o       {lhist, chooser_ctr, gctr, lctr} as read
//   w_v_i        update request
//   w_addr_i     branch PC
//   w_ghist_i    global history used at prediction
//   w_taken_i    resolved direction
//   w_meta_i     meta_o captured at prediction
//   w_yumi_o     update consumed this cycle
// ---------------------------------------------------------------------------
module bp_fe_tournament_bht #(
  parameter  int vaddr_width_p = 39,
  parameter  int ghist_width_p = 8,
  parameter  int lhist_width_p = 8,
  parameter  int lhist_els_p   = 64,
  parameter  int chooser_els_p = 256,
  parameter  int ctr_width_p   = 2,
  localparam int meta_width_lp = lhist_width_p + 3*ctr_width_p
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  output logic                     init_done_o,

  input  logic                     r_v_i,
  input  logic [vaddr_width_p-1:0] r_addr_i,
  input  logic [ghist_width_p-1:0] r_ghist_i,
  output logic                     pred_v_o,
  output logic                     pred_o,
  output logic [meta_width_lp-1:0] meta_o,

  input  logic                     w_v_i,
  input  logic [vaddr_width_p-1:0] w_addr_i,
  input  logic [ghist_width_p-1:0] w_ghist_i,
  input  logic                     w_taken_i,
  input  logic [meta_width_lp-1:0] w_meta_i,
  output logic                     w_yumi_o
);

  localparam int lhe_w_lp     = (lhist_els_p   > 1) ? $clog2(lhist_els_p)   : 1;
  localparam int ch_w_lp      = (chooser_els_p > 1) ? $clog2(chooser_els_p) : 1;
  localparam int lpht_els_lp  = 1 << lhist_width_p;
  localparam int gpht_els_lp  = 1 << ghist_width_p;

  // The clear sweep must reach the deepest structure.
  localparam int max_a_lp     = (lhist_els_p > lpht_els_lp)   ? lhist_els_p : lpht_els_lp;
  localparam int max_b_lp     = (gpht_els_lp > chooser_els_p) ? gpht_els_lp : chooser_els_p;
  localparam int clear_els_lp = (max_a_lp > max_b_lp) ? max_a_lp : max_b_lp;
  localparam int cnt_w_lp     = (clear_els_lp > 1) ? $clog2(clear_els_lp) : 1;
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(clear_els_lp - 1);

  // The weak-not-taken / weak-local init value is 0b01..1.
  localparam logic [ctr_width_p-1:0] ctr_max_lp  = '1;
  localparam logic [ctr_width_p-1:0] ctr_init_lp = {1'b0, {(ctr_width_p-1){1'b1}}};

  typedef enum logic [1:0] {
    e_reset,
    e_clear,
    e_run
  } state_e;

  state_e                state_q;
  logic [cnt_w_lp-1:0]   cnt_q;

  // Storage: counter arrays are synchronous 1RW, lhist is a flop table.
  logic [ctr_width_p-1:0]   lpht_q    [lpht_els_lp];
  logic [ctr_width_p-1:0]   gpht_q    [gpht_els_lp];
  logic [ctr_width_p-1:0]   chooser_q [chooser_els_p];
  logic [lhist_width_p-1:0] lhist_q   [lhist_els_p];

  // IF1 output registers, which hold their value between accepted reads.
  logic                     pred_v_q;
  logic [lhist_width_p-1:0] rd_lhist_q;
  logic [ctr_width_p-1:0]   rd_ch_q;
  logic [ctr_width_p-1:0]   rd_gctr_q;
  logic [ctr_width_p-1:0]   rd_lctr_q;

  // Saturating +/-1 step on a counter.
  function automatic logic [ctr_width_p-1:0] sat_step(input logic [ctr_width_p-1:0] c,
                                                      input logic                   up);
    if (up) return (c == ctr_max_lp) ? c : c + 1'b1;
    else    return (c == '0)         ? c : c - 1'b1;
  endfunction

  // Reset_i also gates traffic in the cycle it is raised. Any in-flight
  // update is therefore refused at once, even though the state register
  // only changes on the next edge.
  logic run_active, clear_active, rd_accept;
  assign run_active   = (state_q == e_run)   & ~reset_i;
  assign clear_active = (state_q == e_clear) & ~reset_i;
  assign init_done_o  = run_active;
  assign w_yumi_o     = w_v_i & run_active;
  assign rd_accept    = r_v_i & run_active & ~w_v_i;

  // Read-side index functions
  logic [lhe_w_lp-1:0]      r_lh_idx;
  logic [ch_w_lp-1:0]       r_ch_idx;
  logic [ghist_width_p-1:0] r_g_idx;
  logic [lhist_width_p-1:0] r_l_idx;
  assign r_lh_idx = r_addr_i[2 +: lhe_w_lp];
  assign r_ch_idx = r_addr_i[2 +: ch_w_lp];
  assign r_g_idx  = r_ghist_i ^ r_addr_i[2 +: ghist_width_p];
  assign r_l_idx  = lhist_q[r_lh_idx];

  // Update-side index functions. The local PHT index comes from the
  // metadata, which holds the history that was live when the prediction
  // was made.
  logic [lhe_w_lp-1:0]      w_lh_idx;
  logic [ch_w_lp-1:0]       w_ch_idx;
  logic [ghist_width_p-1:0] w_g_idx;
  logic [lhist_width_p-1:0] w_l_idx;
  logic [ctr_width_p-1:0]   w_lctr, w_gctr, w_ch;
  assign w_lctr   = w_meta_i[0               +: ctr_width_p];
  assign w_gctr   = w_meta_i[ctr_width_p     +: ctr_width_p];
  assign w_ch     = w_meta_i[2*ctr_width_p   +: ctr_width_p];
  assign w_l_idx  = w_meta_i[3*ctr_width_p   +: lhist_width_p];
  assign w_lh_idx = w_addr_i[2 +: lhe_w_lp];
  assign w_ch_idx = w_addr_i[2 +: ch_w_lp];
  assign w_g_idx  = w_ghist_i ^ w_addr_i[2 +: ghist_width_p];

  // New counter values for an update. The chooser only trains when the
  // two component predictions disagree. It moves toward whichever one
  // matched the outcome.
  logic [ctr_width_p-1:0]   lctr_d, gctr_d, ch_d;
  logic [lhist_width_p-1:0] lhist_d;
  logic                     l_dir, g_dir;
  always_comb begin
    l_dir   = w_lctr[ctr_width_p-1];
    g_dir   = w_gctr[ctr_width_p-1];
    lctr_d  = sat_step(w_lctr, w_taken_i);
    gctr_d  = sat_step(w_gctr, w_taken_i);
    ch_d    = w_ch;
    if (l_dir != g_dir) begin
      ch_d = sat_step(w_ch, g_dir == w_taken_i);
    end
    lhist_d = {lhist_q[w_lh_idx][lhist_width_p-2:0], w_taken_i};
  end

  // Init sequencer: one idle cycle after reset, then a sweep of every
  // index, then normal operation.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_reset;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        e_reset: begin
          state_q <= e_clear;
          cnt_q   <= '0;
        end
        e_clear: begin
          if (cnt_q == cnt_last_lp) state_q <= e_run;
          else                      cnt_q   <= cnt_q + 1'b1;
        end
        e_run:   state_q <= e_run;
        default: state_q <= e_reset;
      endcase
    end
  end

  // Table writes come from the clear sweep or from an accepted update.
  // The clear skips indices that lie past the end of a shallower array.
  // An update writes all three counters back, even when they are unchanged.
  always_ff @(posedge clk_i) begin
    if (clear_active) begin
      if ((cnt_q >> lhist_width_p) == '0) lpht_q[cnt_q[lhist_width_p-1:0]]    <= ctr_init_lp;
      if ((cnt_q >> ghist_width_p) == '0) gpht_q[cnt_q[ghist_width_p-1:0]]    <= ctr_init_lp;
      if ((cnt_q >> ch_w_lp)       == '0) chooser_q[cnt_q[ch_w_lp-1:0]]       <= ctr_init_lp;
      if ((cnt_q >> lhe_w_lp)      == '0) lhist_q[cnt_q[lhe_w_lp-1:0]]        <= '0;
    end else if (w_yumi_o) begin
      lpht_q[w_l_idx]     <= lctr_d;
      gpht_q[w_g_idx]     <= gctr_d;
      chooser_q[w_ch_idx] <= ch_d;
      lhist_q[w_lh_idx]   <= lhist_d;
    end
  end

  // IF1 capture. An accepted read registers the raw counters and the lhist
  // used to index the local PHT. A read that is dropped or idle clears only
  // the valid bit, so the payload keeps its last value.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pred_v_q   <= 1'b0;
      rd_lhist_q <= '0;
      rd_ch_q    <= '0;
      rd_gctr_q  <= '0;
      rd_lctr_q  <= '0;
    end else begin
      pred_v_q <= rd_accept;
      if (rd_accept) begin
        rd_lhist_q <= r_l_idx;
        rd_ch_q    <= chooser_q[r_ch_idx];
        rd_gctr_q  <= gpht_q[r_g_idx];
        rd_lctr_q  <= lpht_q[r_l_idx];
      end
    end
  end

  // The chooser MSB selects the global prediction when set, and the local
  // prediction otherwise.
  assign pred_v_o = pred_v_q;
  assign pred_o   = rd_ch_q[ctr_width_p-1] ? rd_gctr_q[ctr_width_p-1]
                                           : rd_lctr_q[ctr_width_p-1];
  assign meta_o   = {rd_lhist_q, rd_ch_q, rd_gctr_q, rd_lctr_q};

  // Address bits above the index fields do not take part in prediction.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{r_addr_i, w_addr_i};

endmodule

// File: tb/tb_bp_fe_tournament_bht.sv
// ---------------------------------------------------------------------------
// tb_bp_fe_tournament_bht
//
// Self-checking bench for bp_fe_tournament_bht at default parameters. The
// reference model keeps the four tables as plain integer arrays. Indices come
// from shifts and modulo, and counters train with min/max arithmetic.
// ---------------------------------------------------------------------------
module tb_bp_fe_tournament_bht;

  logic        clk;
  logic        reset;
  logic        initDone;
  logic        rV;
  logic [38:0] rAddr;
  logic [7:0]  rGhist;
  logic        predV;
  logic        pred;
  logic [13:0] meta;
  logic        wV;
  logic [38:0] wAddr;
  logic [7:0]  wGhist;
  logic        wTaken;
  logic [13:0] wMeta;
  logic        wYumi;

  int assertCount = 0;
  int failCount   = 0;

  // Reference tables
  int mLpht [256];
  int mGpht [256];
  int mCh   [256];
  int mLhist[64];

  bp_fe_tournament_bht dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .init_done_o (initDone),
    .r_v_i       (rV),
    .r_addr_i    (rAddr),
    .r_ghist_i   (rGhist),
    .pred_v_o    (predV),
    .pred_o      (pred),
    .meta_o      (meta),
    .w_v_i       (wV),
    .w_addr_i    (wAddr),
    .w_ghist_i   (wGhist),
    .w_taken_i   (wTaken),
    .w_meta_i    (wMeta),
    .w_yumi_o    (wYumi)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so that a stuck DUT still ends the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic int lhIdx(input logic [38:0] a);
    return int'((a >> 2) % 64);
  endfunction

  function automatic int chIdx(input logic [38:0] a);
    return int'((a >> 2) % 256);
  endfunction

  function automatic int gIdx(input logic [38:0] a, input logic [7:0] g);
    return int'((g ^ (a >> 2)) % 256);
  endfunction

  function automatic int satMove(input int c, input logic up);
    if (up) return (c < 3) ? c + 1 : 3;
    else    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic logic [13:0] expMeta(input logic [38:0] a, input logic [7:0] g);
    int lh;
    lh = mLhist[lhIdx(a)];
    return {8'(lh), 2'(mCh[chIdx(a)]), 2'(mGpht[gIdx(a, g)]), 2'(mLpht[lh])};
  endfunction

  function automatic logic expPred(input logic [13:0] m);
    int c, gc, lc;
    c  = int'(m[5:4]);
    gc = int'(m[3:2]);
    lc = int'(m[1:0]);
    return (c >= 2) ? (gc >= 2) : (lc >= 2);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 256; i++) begin
      mLpht[i] = 1;
      mGpht[i] = 1;
      mCh[i]   = 1;
    end
    for (int i = 0; i < 64; i++) mLhist[i] = 0;
  endtask

  task automatic modelUpdate(input logic [38:0] a, input logic [7:0] g,
                             input logic t, input logic [13:0] m);
    int lc, gc, cc, lh, li;
    lc = int'(m[1:0]);
    gc = int'(m[3:2]);
    cc = int'(m[5:4]);
    lh = int'(m[13:6]);
    if ((lc >= 2) != (gc >= 2)) cc = satMove(cc, (gc >= 2) == t);
    mLpht[lh]       = satMove(lc, t);
    mGpht[gIdx(a, g)] = satMove(gc, t);
    mCh[chIdx(a)]   = cc;
    li = lhIdx(a);
    mLhist[li] = (mLhist[li] * 2 + int'(t)) % 256;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    modelReset();
  endtask

  task automatic waitInit(output int cycles);
    cycles = 0;
    while (initDone !== 1'b1 && cycles < 2000) begin
      step();
      cycles++;
    end
  endtask

  task automatic applyRead(input logic [38:0] a, input logic [7:0] g);
    rV     = 1'b1;
    rAddr  = a;
    rGhist = g;
    step();
    rV     = 1'b0;
  endtask

  task automatic applyWrite(input logic [38:0] a, input logic [7:0] g, input logic t,
                            input logic [13:0] m, output logic yumiSeen);
    wV     = 1'b1;
    wAddr  = a;
    wGhist = g;
    wTaken = t;
    wMeta  = m;
    #1;
    yumiSeen = wYumi;
    @(posedge clk);
    #1;
    wV = 1'b0;
    modelUpdate(a, g, t, m);
  endtask

  function automatic logic [38:0] randAddr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[38:0];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int cycles;
    logic [38:0] a;
    logic [7:0]  g;
    doReset();
    wV = 1'b1;
    rV = 1'b1;
    #1;
    assertCount++;
    if (initDone !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_init_done: got %b want 0", initDone);
    end
    assertCount++;
    if (wYumi !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_yumi: got %b want 0", wYumi);
    end
    assertCount++;
    if (predV !== 1'b0 || pred !== 1'b0 || meta !== 14'h0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got pred_v=%b pred=%b meta=%h want 0/0/0000", predV, pred, meta);
    end
    wV = 1'b0;
    rV = 1'b0;
    waitInit(cycles);
    assertCount++;
    if (cycles !== 257) begin
      failCount++; $display("[TB] FAIL clear_latency: got %0d cycles want 257", cycles);
    end
    for (int i = 0; i < 2; i++) begin
      a = randAddr();
      g = 8'($urandom);
      applyRead(a, g);
      assertCount++;
      if (predV !== 1'b1 || pred !== 1'b0 || meta !== 14'h015) begin
        failCount++;
        $display("[TB] FAIL first_read: got pred_v=%b pred=%b meta=%h want 1/0/0015", predV, pred, meta);
      end
    end
  endtask

  task automatic test_saturation();
    logic [13:0] m;
    logic        y;
    m = 14'h015;
    for (int i = 0; i < 5; i++) begin
      applyWrite(39'h1000, 8'h00, 1'b1, m, y);
      assertCount++;
      if (y !== 1'b1) begin
        failCount++; $display("[TB] FAIL sat_taken_yumi: got %b want 1", y);
      end
      m = {8'h00, 2'(mCh[0]), 2'(mGpht[0]), 2'(mLpht[0])};
    end
    applyRead(39'h1104, 8'h41);
    assertCount++;
    if (meta[1:0] !== 2'b11 || meta[3:2] !== 2'b11 || meta !== expMeta(39'h1104, 8'h41)) begin
      failCount++;
      $display("[TB] FAIL sat_high: got meta=%h want %h with lctr=gctr=11", meta, expMeta(39'h1104, 8'h41));
    end
    for (int i = 0; i < 5; i++) begin
      applyWrite(39'h1000, 8'h00, 1'b0, m, y);
      m = {8'h00, 2'(mCh[0]), 2'(mGpht[0]), 2'(mLpht[0])};
    end
    applyRead(39'h1104, 8'h41);
    assertCount++;
    if (meta[1:0] !== 2'b00 || meta[3:2] !== 2'b00 || meta !== expMeta(39'h1104, 8'h41)) begin
      failCount++;
      $display("[TB] FAIL sat_low: got meta=%h want %h with lctr=gctr=00", meta, expMeta(39'h1104, 8'h41));
    end
  endtask

  task automatic test_chooser();
    logic y;
    applyWrite(39'h3010, 8'h00, 1'b1, {8'h30, 2'b01, 2'b11, 2'b00}, y);
    applyRead(39'h3010, 8'h00);
    assertCount++;
    if (meta[5:4] !== 2'b10 || meta[3:2] !== 2'b11) begin
      failCount++; $display("[TB] FAIL chooser_train: got chooser=%b gctr=%b want 10/11", meta[5:4], meta[3:2]);
    end
    assertCount++;
    if (pred !== 1'b1 || meta !== expMeta(39'h3010, 8'h00)) begin
      failCount++;
      $display("[TB] FAIL chooser_pred: got pred=%b meta=%h want 1/%h", pred, meta, expMeta(39'h3010, 8'h00));
    end
  endtask

  task automatic test_local_history();
    logic y;
    // Give local PHT entry 7 a distinctive value first
    applyWrite(39'h2020, 8'h00, 1'b1, {8'h07, 2'b01, 2'b01, 2'b01}, y);
    applyWrite(39'h2020, 8'h00, 1'b1, {8'h07, 2'b01, 2'b01, 2'b10}, y);
    for (int i = 0; i < 3; i++) applyWrite(39'h2004, 8'h00, 1'b1, 14'h015, y);
    applyRead(39'h2004, 8'h00);
    assertCount++;
    if (meta[13:6] !== 8'h07) begin
      failCount++; $display("[TB] FAIL lhist_value: got %h want 07", meta[13:6]);
    end
    assertCount++;
    if (meta[1:0] !== 2'b11 || meta !== expMeta(39'h2004, 8'h00) || pred !== expPred(expMeta(39'h2004, 8'h00))) begin
      failCount++;
      $display("[TB] FAIL lhist_index: got meta=%h pred=%b want %h (lctr from entry 7 = 11)", meta, pred, expMeta(39'h2004, 8'h00));
    end
  endtask

  task automatic test_conflict();
    logic [13:0] held;
    logic [13:0] m;
    applyRead(39'h4000, 8'h12);
    held = expMeta(39'h4000, 8'h12);
    // Idle cycle: valid drops, payload holds
    step();
    assertCount++;
    if (predV !== 1'b0 || meta !== held) begin
      failCount++; $display("[TB] FAIL idle_hold: got pred_v=%b meta=%h want 0/%h", predV, meta, held);
    end
    m = 14'($urandom);
    rV = 1'b1; rAddr = 39'h4000; rGhist = 8'h12;
    wV = 1'b1; wAddr = 39'h4000; wGhist = 8'h12; wTaken = 1'b1; wMeta = m;
    #1;
    assertCount++;
    if (wYumi !== 1'b1) begin
      failCount++; $display("[TB] FAIL conflict_yumi: got %b want 1", wYumi);
    end
    @(posedge clk);
    #1;
    rV = 1'b0;
    wV = 1'b0;
    modelUpdate(39'h4000, 8'h12, 1'b1, m);
    assertCount++;
    if (predV !== 1'b0 || meta !== held) begin
      failCount++; $display("[TB] FAIL conflict_drop: got pred_v=%b meta=%h want 0/%h", predV, meta, held);
    end
    applyRead(39'h4000, 8'h12);
    assertCount++;
    if (predV !== 1'b1 || meta !== expMeta(39'h4000, 8'h12)) begin
      failCount++;
      $display("[TB] FAIL conflict_retry: got pred_v=%b meta=%h want 1/%h", predV, meta, expMeta(39'h4000, 8'h12));
    end
  endtask

  task automatic test_back_to_back();
    logic [38:0] a;
    logic [7:0]  g;
    logic        y;
    a = randAddr();
    g = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      applyWrite(a, g, 1'($urandom), 14'($urandom), y);
      assertCount++;
      if (y !== 1'b1) begin
        failCount++; $display("[TB] FAIL b2b_yumi[%0d]: got %b want 1", i, y);
      end
    end
    applyRead(a, g);
    assertCount++;
    if (predV !== 1'b1 || meta !== expMeta(a, g) || pred !== expPred(expMeta(a, g))) begin
      failCount++;
      $display("[TB] FAIL b2b_read: got pred_v=%b pred=%b meta=%h want 1/%b/%h", predV, pred, meta, expPred(expMeta(a, g)), expMeta(a, g));
    end
  endtask

  task automatic test_random();
    logic [38:0] a, lastA;
    logic [7:0]  g, lastG;
    logic [13:0] em;
    logic        y;
    int          op;
    lastA = randAddr();
    lastG = 8'($urandom);
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        a = lastA; g = lastG;
      end else begin
        a = randAddr(); g = 8'($urandom);
      end
      if (op != 0) begin
        applyWrite(a, g, 1'($urandom), 14'($urandom), y);
        assertCount++;
        if (y !== 1'b1) begin
          failCount++; $display("[TB] FAIL rand_yumi[%0d]: got %b want 1", i, y);
        end
      end
      if (op != 1) begin
        em = expMeta(a, g);
        applyRead(a, g);
        assertCount++;
        if (predV !== 1'b1 || meta !== em || pred !== expPred(em)) begin
          failCount++;
          $display("[TB] FAIL rand_read[%0d]: got pred_v=%b pred=%b meta=%h want 1/%b/%h", i, predV, pred, meta, expPred(em), em);
        end
      end
      lastA = a;
      lastG = g;
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    logic [38:0] addrs [3];
    logic [7:0]  ghs   [3];
    addrs[0] = 39'h1104; ghs[0] = 8'h41;
    addrs[1] = 39'h2004; ghs[1] = 8'h00;
    addrs[2] = 39'h3010; ghs[2] = 8'h00;
    // Reset while the clear counter is at 100
    doReset();
    for (int i = 0; i < 101; i++) step();
    reset = 1'b1;
    wV = 1'b1; wAddr = 39'h2004; wGhist = 8'h00; wTaken = 1'b1; wMeta = 14'h015;
    #1;
    assertCount++;
    if (initDone !== 1'b0 || wYumi !== 1'b0) begin
      failCount++; $display("[TB] FAIL midclear_reset: got init_done=%b yumi=%b want 0/0", initDone, wYumi);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    wV = 1'b0;
    modelReset();
    waitInit(cycles);
    assertCount++;
    if (cycles !== 257) begin
      failCount++; $display("[TB] FAIL midclear_latency: got %0d cycles want 257", cycles);
    end
    // Reset raised together with a write in the run state
    wV = 1'b1;
    #1;
    assertCount++;
    if (wYumi !== 1'b1) begin
      failCount++; $display("[TB] FAIL run_yumi_prereset: got %b want 1", wYumi);
    end
    reset = 1'b1;
    #1;
    assertCount++;
    if (initDone !== 1'b0 || wYumi !== 1'b0) begin
      failCount++; $display("[TB] FAIL midwrite_reset: got init_done=%b yumi=%b want 0/0", initDone, wYumi);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    wV = 1'b0;
    modelReset();
    waitInit(cycles);
    assertCount++;
    if (cycles !== 257) begin
      failCount++; $display("[TB] FAIL midwrite_latency: got %0d cycles want 257", cycles);
    end
    for (int i = 0; i < 3; i++) begin
      applyRead(addrs[i], ghs[i]);
      assertCount++;
      if (predV !== 1'b1 || pred !== 1'b0 || meta !== 14'h015 || meta !== expMeta(addrs[i], ghs[i])) begin
        failCount++;
        $display("[TB] FAIL reclear_entry[%0d]: got pred_v=%b pred=%b meta=%h want 1/0/0015", i, predV, pred, meta);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    rV     = 1'b0;
    rAddr  = '0;
    rGhist = '0;
    wV     = 1'b0;
    wAddr  = '0;
    wGhist = '0;
    wTaken = 1'b0;
    wMeta  = '0;
    modelReset();
    $display("[TB] starting bp_fe_tournament_bht bench");
    test_reset();
    test_saturation();
    test_chooser();
    test_local_history();
    test_conflict();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
